// File: rtl/host_seq_pkg.sv
// host_seq_pkg: shared types for the host-port sequencer.
// Widths match the four-host arbiter host port (32-bit address/data, 4 byte enables).
// Holds the sequencer state enum and the buffered command struct.
package host_seq_pkg;

  localparam int HSEQ_AW = 32;
  localparam int HSEQ_DW = 32;
  localparam int HSEQ_BW = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic               wr;
    logic [HSEQ_AW-1:0] addr;
    logic [HSEQ_BW-1:0] be;
    logic [HSEQ_DW-1:0] data;
    logic               cpu;
  } cmd_t;

endpackage

// File: rtl/host_seq_fifo.sv
// host_seq_fifo: synchronous FIFO of command structs with level/full/empty.
// Latency: a push is visible at the head (and in level) one cycle later; head is combinational.
// Backpressure: pushes while full and pops while empty are ignored.
module host_seq_fifo
  import host_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  cmd_t                  push_cmd,
  input  logic                  pop,
  output cmd_t                  head,
  output logic [$clog2(DEPTH):0] level,
  output logic                  full,
  output logic                  empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_LEVEL = (PW+1)'(DEPTH);

  cmd_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking; simultaneous push and pop keep the level
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage array; contents need no reset since level gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_cmd;
  end

endmodule

// File: rtl/host_seq.sv
// host_seq: issues buffered read/write commands one at a time on an arbiter host port.
// Latency: push to strobe 2 cycles; ack to rsp_valid 1 cycle. Optional retry: HSEQ_RETRY_EN.
// Backpressure: cmd_ready = !full; a held response (rsp_ready low) stalls further issue.
module host_seq
  import host_seq_pkg::*;
#(
  parameter int AW        = HSEQ_AW,
  parameter int DW        = HSEQ_DW,
  parameter int BW        = HSEQ_BW,
  parameter int DEPTH     = 4,
  parameter int RETRY_MAX = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_wr,
  input  logic [AW-1:0]          cmd_addr,
  input  logic [BW-1:0]          cmd_be,
  input  logic [DW-1:0]          cmd_data,
  input  logic                   cmd_cpu,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DW-1:0]          rsp_data,
  output logic                   rsp_wr,
  output logic                   rsp_timeout,
  output logic                   hcpu,
  output logic [AW-1:0]          haddr,
  output logic [BW-1:0]          hbe,
  output logic [DW-1:0]          hdwr,
  output logic                   hrd,
  output logic                   hwr,
  input  logic [DW-1:0]          hdrd,
  input  logic [1:0]             hack,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [7:0]             err_cnt
);

  state_t state;
  state_t state_nxt;
  cmd_t   cmd_in;
  cmd_t   head;
  cmd_t   wk;
  logic   fifo_full;
  logic   fifo_empty;
  logic   pop;
  logic   ack;
  logic   ack_to;
  logic   retry_avail;
  logic   finish;

  assign ack    = hack[0];
  assign ack_to = hack[1];

  assign cmd_in = '{wr: cmd_wr, addr: cmd_addr, be: cmd_be, data: cmd_data, cpu: cmd_cpu};

  host_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (cmd_valid),
    .push_cmd (cmd_in),
    .pop      (pop),
    .head     (head),
    .level    (fifo_level),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign cmd_ready = !fifo_full;
  // The working register is loaded exactly on the IDLE->ISSUE step
  assign pop       = (state == IDLE) && !fifo_empty;
  // Attempt completes into a response (as opposed to looping through GAP)
  assign finish    = (state == ISSUE) && ack && !(ack_to && retry_avail);

`ifdef HSEQ_RETRY_EN
  localparam int RCW = $clog2(RETRY_MAX + 2);
  logic [RCW-1:0] retry_cnt;

  // Reissue count for the current command; cleared when a new command is loaded
  always_ff @(posedge clk) begin
    if (reset)              retry_cnt <= '0;
    else if (pop)           retry_cnt <= '0;
    else if (state == GAP)  retry_cnt <= retry_cnt + 1'b1;
  end

  assign retry_avail = (retry_cnt < RCW'(RETRY_MAX));
`else
  // Retries compiled out: every timeout ends the command (RETRY_MAX kept for a shared parameter list)
  assign retry_avail = 1'b0 & (RETRY_MAX != 0);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; hack is only honoured in ISSUE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!fifo_empty) state_nxt = ISSUE;
      ISSUE: if (ack) state_nxt = (ack_to && retry_avail) ? GAP : RESP;
`ifdef HSEQ_RETRY_EN
      GAP:   state_nxt = ISSUE;
`endif
      RESP:  if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Host-port outputs; the strobe is masked by the ack pulse so it drops in the ack cycle
  always_comb begin
    hcpu      = 1'b0;
    haddr     = '0;
    hbe       = '0;
    hdwr      = '0;
    hrd       = 1'b0;
    hwr       = 1'b0;
    rsp_valid = (state == RESP);
    busy      = !fifo_empty || (state != IDLE);
    if (state == ISSUE) begin
      hcpu  = wk.cpu;
      haddr = wk.addr;
      hbe   = wk.be;
      hdwr  = wk.data;
      hrd   = !wk.wr && !ack;
      hwr   = wk.wr && !ack;
    end
  end

  // Working command, response capture and saturating timeout counter
  always_ff @(posedge clk) begin
    if (reset) begin
      wk          <= '0;
      rsp_data    <= '0;
      rsp_wr      <= 1'b0;
      rsp_timeout <= 1'b0;
      err_cnt     <= '0;
    end else begin
      if (pop) wk <= head;
      if (finish) begin
        rsp_data    <= wk.wr ? '0 : hdrd;
        rsp_wr      <= wk.wr;
        rsp_timeout <= ack_to;
        if (ack_to && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule
